// File: rtl/s3g_pkg.sv
// s3g_pkg: shared types and constants for the s3g interrupt controller and packet transmitter
package s3g_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} int_state_t;
   localparam int INT_LOOPBACK = 31;
   localparam int INT_BE_COMPLETE = 30;
   localparam logic [15:0] REPORT_ID = 16'hFFFF;
   localparam logic [7:0] REPORT_CMD = 8'h50;
endpackage

// File: rtl/s3g_int_timer.sv
// s3g_int_timer: loadable down-counter that saturates at zero
//   clk, rst_n    clock, asynchronous active-low reset
//   i_load        load i_load_val (has priority over i_en)
//   i_en          decrement by one while nonzero
//   o_zero        counter currently holds zero
module s3g_int_timer #(
   parameter int TIMER_W = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic               i_en,
   input  logic [TIMER_W-1:0] i_load_val,
   output logic               o_zero
);
   logic [TIMER_W-1:0] r_count;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_count <= '0;
      else if (i_load) r_count <= i_load_val;
      else if (i_en && r_count != '0) r_count <= r_count - 1'b1;
   assign o_zero = (r_count == '0);
endmodule

// File: rtl/s3g_int_ctrl.sv
// s3g_int_ctrl: edge/level interrupt collector with mask, clear and periodic re-reporting
//   int_src                      interrupt sources, synchronous to clk
//   mode_wr/mode_data            per-channel mode, 1 = level, 0 = edge
//   mask_wr/mask_data            channel enables, 1 = enabled
//   clear_wr/clear_data          write-1-to-clear pending bits
//   ints_pending/ints_mask       pending and mask registers
//   report_req/report_data       report request and snapshot of pending & mask
//   report_ack                   one-cycle acceptance pulse from the transmitter
module s3g_int_ctrl import s3g_pkg::*; #(
   parameter int NUM_INTS     = 32,
   parameter int REPORT_TIMER = 15000,
   parameter int TIMER_W      = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_INTS-1:0] int_src,
   input  logic                mode_wr,
   input  logic [NUM_INTS-1:0] mode_data,
   input  logic                mask_wr,
   input  logic [NUM_INTS-1:0] mask_data,
   input  logic                clear_wr,
   input  logic [NUM_INTS-1:0] clear_data,
   output logic [NUM_INTS-1:0] ints_pending,
   output logic [NUM_INTS-1:0] ints_mask,
   output logic                report_req,
   output logic [NUM_INTS-1:0] report_data,
   input  logic                report_ack
);
   logic [NUM_INTS-1:0] r_int_prev, r_mode, r_pending, r_mask, r_reported, r_report_data;
   logic [NUM_INTS-1:0] w_set, w_clr, w_active, w_new;
   logic                w_load, w_en, w_zero;
   int_state_t          r_state, w_next;
   // level channels set while high, edge channels only on a rising edge
   assign w_set    = int_src & (r_mode | ~r_int_prev);
   assign w_clr    = clear_wr ? clear_data : '0;
   assign w_active = r_pending & r_mask;
   assign w_new    = w_active & ~r_reported;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_int_prev <= '0;
         r_pending  <= '0;
         r_mask     <= '1;
         r_mode     <= '0;
      end else begin
         r_int_prev <= int_src;
         r_pending  <= (r_pending & ~w_clr) | w_set;
         if (mask_wr) r_mask <= mask_data;
         if (mode_wr) r_mode <= mode_data;
      end
   // reported tracks the last snapshot sent so HOLD can spot newly active bits;
   // it is cleared whenever nothing is active so the next appearance counts as new
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_reported    <= '0;
         r_report_data <= '0;
      end else if (r_state == ST_IDLE) begin
         r_reported <= w_active;
         if (|w_active) r_report_data <= w_active;
      end else if (r_state == ST_HOLD && ~|w_active) begin
         r_reported <= '0;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= ST_IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: w_next = |w_active ? ST_REQ : ST_IDLE;
         ST_REQ:  w_next = report_ack ? ST_HOLD : ST_REQ;
         ST_HOLD: w_next = (|w_new || w_zero) ? ST_IDLE : ST_HOLD;
         default: w_next = ST_IDLE;
      endcase
   end
   always_comb begin
      report_req = (r_state == ST_REQ);
      w_load     = report_req && report_ack;
      w_en       = (r_state == ST_HOLD);
   end
   s3g_int_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_en       (w_en),
      .i_load_val (TIMER_W'(REPORT_TIMER - 1)),
      .o_zero     (w_zero)
   );
   assign ints_pending = r_pending;
   assign ints_mask    = r_mask;
   assign report_data  = r_report_data;
endmodule

// File: tb/tb_s3g_int_ctrl.sv
// tb_s3g_int_ctrl: scoreboard bench with a behavioural pending/mask model and a transmitter ack model
module tb_s3g_int_ctrl;
   localparam int N  = 32;
   localparam int RT = 100;
   logic clk = 0, rst_n = 0;
   logic [N-1:0] int_src = '0, mode_data = '0, mask_data = '0, clear_data = '0;
   logic mode_wr = 0, mask_wr = 0, clear_wr = 0, report_ack = 0;
   logic [N-1:0] ints_pending, ints_mask, report_data;
   logic report_req;
   logic ack_en = 1, stray_en = 0;
   int n_pass = 0, n_total = 0, n_reports = 0;
   logic [N-1:0] exp_q[$];
   logic [N-1:0] m_pend, m_mask, m_mode, m_prev, last_active, held;
   logic prev_req = 0;

   always #5 clk = ~clk;

   s3g_int_ctrl #(.NUM_INTS(N), .REPORT_TIMER(RT), .TIMER_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .int_src(int_src),
      .mode_wr(mode_wr), .mode_data(mode_data),
      .mask_wr(mask_wr), .mask_data(mask_data),
      .clear_wr(clear_wr), .clear_data(clear_data),
      .ints_pending(ints_pending), .ints_mask(ints_mask),
      .report_req(report_req), .report_data(report_data), .report_ack(report_ack)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // reference: a channel becomes pending when its source is high (level) or rises (edge);
   // a clear drops a bit only when no new set arrives in the same cycle
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_pend <= '0;
         m_mask <= '1;
         m_mode <= '0;
         m_prev <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (m_mode[i] ? int_src[i] : (int_src[i] && !m_prev[i])) m_pend[i] <= 1'b1;
            else if (clear_wr && clear_data[i]) m_pend[i] <= 1'b0;
         end
         m_prev <= int_src;
         if (mask_wr) m_mask <= mask_data;
         if (mode_wr) m_mode <= mode_data;
      end

   // monitor: registers against the model every cycle, each new report against the
   // scoreboard queue and against the enabled pending set of the deciding cycle
   always @(negedge clk) begin
      check("pending", 64'(ints_pending), 64'(m_pend));
      check("mask", 64'(ints_mask), 64'(m_mask));
      if (report_req && !prev_req) begin
         n_reports++;
         check("rep_model", 64'(report_data), 64'(last_active));
         if (exp_q.size() > 0) check("rep_exp", 64'(report_data), 64'(exp_q.pop_front()));
         held = report_data;
      end else if (report_req) check("rep_stable", 64'(report_data), 64'(held));
      prev_req = report_req;
      last_active = m_pend & m_mask;
   end

   // transmitter: acks 5 cycles into each request, optional stray acks when idle
   initial begin : ack_model
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (report_req) begin
            cnt++;
            report_ack = ack_en && cnt == 5;
         end else begin
            cnt = 0;
            report_ack = stray_en && $urandom_range(0, 15) == 0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic lvl, input int limit, input string name, output int cyc);
      cyc = 0;
      while (report_req !== lvl && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      check(name, 64'(report_req), 64'(lvl));
   endtask

   task automatic no_report(input int n, input string name);
      int start;
      start = n_reports;
      repeat (n) @(negedge clk);
      check(name, 64'(n_reports - start), 64'd0);
   endtask

   initial begin
      int cyc;
      tick(3);
      check("rst_pending", 64'(ints_pending), 64'd0);
      check("rst_mask", 64'(ints_mask), 64'hFFFFFFFF);
      check("rst_req", 64'(report_req), 64'd0);
      check("rst_data", 64'(report_data), 64'd0);
      rst_n = 1;
      tick(2);
      // 1: edge pulse, first report, periodic re-report
      exp_q.push_back(32'h80000000);
      int_src = 32'h80000000;
      tick(1);
      int_src = '0;
      wait_req(1, 3, "t1_req", cyc);
      check("t1_pending", 64'(ints_pending), 64'h80000000);
      wait_req(0, 10, "t1_ack", cyc);
      exp_q.push_back(32'h80000000);
      wait_req(1, RT + 10, "t1_rereport", cyc);
      check("t1_period", 64'(cyc >= RT - 1 && cyc <= RT + 3), 64'd1);
      wait_req(0, 10, "t1_ack2", cyc);
      // 2: masking suppresses reports, unmasking reports at once
      tick(1);
      mask_wr = 1; mask_data = 32'h7FFFFFFF;
      tick(1);
      mask_wr = 0;
      no_report(300, "t2_masked_quiet");
      check("t2_pending_kept", 64'(ints_pending), 64'h80000000);
      tick(1);
      exp_q.push_back(32'h80000000);
      mask_wr = 1; mask_data = 32'hFFFFFFFF;
      tick(1);
      mask_wr = 0;
      wait_req(1, 3, "t2_unmask_req", cyc);
      // 3: clear during HOLD, no report at timer expiry
      wait_req(0, 10, "t3_ack", cyc);
      tick(1);
      clear_wr = 1; clear_data = 32'h80000000;
      tick(1);
      clear_wr = 0;
      no_report(300, "t3_cleared_quiet");
      check("t3_pending", 64'(ints_pending), 64'd0);
      // 4: new bit during REQ merges into the report that follows the ack
      tick(1);
      exp_q.push_back(32'h80000000);
      int_src = 32'h80000000;
      tick(1);
      int_src = '0;
      wait_req(1, 3, "t4_req", cyc);
      tick(1);
      exp_q.push_back(32'hC0000000);
      int_src = 32'h40000000;
      tick(1);
      int_src = '0;
      @(negedge clk);
      check("t4_still_req", 64'(report_req), 64'd1);
      check("t4_data_held", 64'(report_data), 64'h80000000);
      wait_req(0, 10, "t4_ack", cyc);
      wait_req(1, 4, "t4_fast_req", cyc);
      wait_req(0, 10, "t4_ack2", cyc);
      tick(1);
      clear_wr = 1; clear_data = 32'hC0000000;
      tick(1);
      clear_wr = 0;
      no_report(150, "t4_quiet");
      // 5: level channel re-pends while held, stays clear once dropped
      tick(1);
      mode_wr = 1; mode_data = 32'h00000020;
      tick(1);
      mode_wr = 0;
      int_src = 32'h00000020;
      tick(3);
      clear_wr = 1; clear_data = 32'h00000020;
      tick(1);
      clear_wr = 0;
      check("t5_level_repend", 64'(ints_pending[5]), 64'd1);
      int_src = '0;
      tick(2);
      clear_wr = 1; clear_data = 32'h00000020;
      tick(1);
      clear_wr = 0;
      tick(3);
      check("t5_level_cleared", 64'(ints_pending[5]), 64'd0);
      mode_wr = 1; mode_data = '0;
      tick(1);
      mode_wr = 0;
      repeat (250) @(negedge clk);
      // 6: set beats clear, then reset in the middle of a request
      tick(1);
      int_src = 32'h00000008;
      tick(1);
      int_src = '0;
      wait_req(1, 3, "t6_req", cyc);
      wait_req(0, 10, "t6_ack", cyc);
      tick(1);
      ack_en = 0;
      int_src = 32'h00000008;
      clear_wr = 1; clear_data = 32'h00000008;
      tick(1);
      int_src = '0;
      clear_wr = 0;
      check("t6_set_wins", 64'(ints_pending[3]), 64'd1);
      wait_req(1, RT + 20, "t6_rereport", cyc);
      tick(2);
      #1 rst_n = 0;
      #1;
      check("t6_rst_req", 64'(report_req), 64'd0);
      check("t6_rst_pending", 64'(ints_pending), 64'd0);
      check("t6_rst_mask", 64'(ints_mask), 64'hFFFFFFFF);
      check("t6_rst_data", 64'(report_data), 64'd0);
      tick(2);
      rst_n = 1;
      ack_en = 1;
      tick(2);
      // random traffic with stray acks, checked against the model
      stray_en = 1;
      repeat (3000) begin
         tick(1);
         int_src    = ($urandom_range(0, 3) == 0) ? int_src ^ ($urandom & $urandom & $urandom) : int_src;
         mask_wr    = $urandom_range(0, 31) == 0;
         mask_data  = $urandom | $urandom;
         mode_wr    = $urandom_range(0, 63) == 0;
         mode_data  = $urandom & $urandom;
         clear_wr   = $urandom_range(0, 7) == 0;
         clear_data = $urandom;
      end
      tick(1);
      {mask_wr, mode_wr, clear_wr, stray_en} = '0;
      tick(20);
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
